vga_pixel_fetch: RTL and testbench
==================================

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001: Parameter IMG_W, default 160, is the source image width in pixels.
REQ-002: Parameter IMG_H, default 120, is the source image height in pixels.
REQ-003: Parameter SCALE_SHIFT, default 2, is the upscale factor expressed as log2 (2 = 4x).
REQ-004: Parameter ADDR_W, default 16, is the frame-buffer address width; it SHALL hold 2*IMG_W*IMG_H-1.
REQ-005: Parameter BORDER_RGB, default 12'h000, is the colour shown for visible pixels outside the image or transparent pixels.
REQ-006: Port clk, input, 1 bit, is the 25 MHz pixel clock.
REQ-007: Port reset_n, input, 1 bit, is a synchronous, active-low reset.
REQ-008: Port x, input, 10 bits, is the upstream horizontal pixel count.
REQ-009: Port y, input, 10 bits, is the upstream vertical line count.
REQ-010: Port video_on, input, 1 bit, is the upstream visible-area flag.
REQ-011: Ports hsync_in and vsync_in, input, 1 bit each, are the upstream registered sync signals.
REQ-012: Port fb_addr, output, ADDR_W bits, is the frame-buffer read address.
REQ-013: Port fb_rdata, input, 8 bits, is the palette index; it is valid 1 cycle after fb_addr.
REQ-014: Port pal_addr, output, 8 bits, is the palette RAM address.
REQ-015: Port pal_rdata, input, 12 bits, is the RGB444 value; it is valid 1 cycle after pal_addr.
REQ-016: Port transp_en, input, 1 bit, enables the transparent index.
REQ-017: Port transp_idx, input, 8 bits, is the transparent index.
REQ-018: Port swap_req, input, 1 bit, is a one-cycle pulse from the decoder meaning the back bank is complete.
REQ-019: Ports rgb (output, 12 bits), hsync_out (output, 1 bit) and vsync_out (output, 1 bit) are the aligned pixel and sync outputs.
REQ-020: Ports bank_sel, swap_ack and frame_done are 1-bit outputs: the displayed bank, the swap-done pulse and the end-of-visible-frame pulse.
REQ-021: Port frame_cnt, output, 16 bits, counts displayed frames.

Function
REQ-022: Pipeline timing, with inputs sampled at cycle t:
- fb_addr is registered at t+1.
- fb_rdata arrives at t+2.
- pal_rdata arrives at t+3.
- rgb, hsync_out and vsync_out are registered at t+4.
- Total latency SHALL be exactly 4 cycles.
REQ-023: Column and row SHALL be col = x >> SCALE_SHIFT and row = y >> SCALE_SHIFT.
REQ-024: in_img SHALL equal video_on AND col < IMG_W AND row < IMG_H.
REQ-025: When in_img is true, fb_addr SHALL be row*IMG_W + col + (bank_sel ? IMG_W*IMG_H : 0), computed in ADDR_W bits with no overflow.
REQ-026: When in_img is false, fb_addr SHALL hold its previous value.
REQ-027: pal_addr SHALL equal fb_rdata (combinational pass-through).
REQ-028: video_on, in_img, the hsync_in/vsync_in pair and a transparency flag SHALL be carried through the pipeline aligned with the data.
- The transparency flag is transp_en AND fb_rdata == transp_idx, evaluated at t+2.
REQ-029: rgb at t+4 SHALL be pal_rdata when delayed in_img is true and the pixel is not transparent.
REQ-030: rgb at t+4 SHALL be BORDER_RGB when delayed video_on is true and either in_img is false or the pixel is transparent.
REQ-031: rgb at t+4 SHALL be 0 when delayed video_on is false.
REQ-032: hsync_out and vsync_out SHALL be hsync_in and vsync_in delayed by exactly 4 cycles, with polarity unchanged.
REQ-033: The boundary cycle SHALL be the input cycle where x == 639 and y == 479.
REQ-034: frame_done SHALL pulse high for 1 cycle in the cycle after every boundary cycle.
REQ-035: frame_cnt SHALL increment in the cycle after every boundary cycle and wrap from 16'hFFFF to 0.
REQ-036: The swap state machine SHALL have two states, IDLE and PENDING.
REQ-037: swap_req in IDLE SHALL move the machine to PENDING.
REQ-038: swap_req while already PENDING SHALL be ignored (no queueing).
REQ-039: If the machine is PENDING at a boundary cycle, or swap_req is asserted in the boundary cycle itself:
- bank_sel toggles in the next cycle.
- swap_ack pulses for 1 cycle in that same next cycle.
- The machine returns to IDLE.
REQ-040: bank_sel SHALL change only after a boundary cycle, so a visible frame never mixes banks.

Reset
REQ-041: When reset_n is 0 at a clk edge, all outputs SHALL go to 0 in that cycle:
- fb_addr, rgb, hsync_out, vsync_out;
- bank_sel, swap_ack, frame_done, frame_cnt;
- all pipeline state; the swap machine returns to IDLE.
REQ-042: A reset asserted mid-frame or while PENDING SHALL discard the pending swap.
REQ-043: After reset_n is released, pipeline outputs SHALL be valid from the 4th cycle onward.

Verification
REQ-044: Address mapping: x=5, y=9, video_on=1, bank_sel=0 -> fb_addr=321 at t+1. With bank_sel=1 -> fb_addr=19521.
REQ-045: Latency: drive fb_rdata=8'h2A at t+2 and pal_rdata=12'hF80 at t+3 -> rgb=12'hF80 at t+4. A hsync_in edge at t appears on hsync_out at exactly t+4.
REQ-046: Border and transparency, with IMG_W=100 overridden:
- x=400 (col=100) -> rgb=BORDER_RGB.
- transp_en=1, transp_idx=8'h05, fb_rdata=8'h05 -> rgb=BORDER_RGB.
- video_on=0 -> rgb=0.
REQ-047: Swap:
- swap_req at y=100 -> bank_sel stays 0 through the frame, then toggles to 1 with a swap_ack pulse the cycle after x=639, y=479.
- A second swap_req while PENDING -> still only one toggle.
- swap_req in the boundary cycle itself -> toggles at that boundary.
REQ-048: Reset: assert reset_n=0 while PENDING mid-frame -> all outputs are 0 next cycle and no swap occurs at the following boundary.
REQ-049: Counter wrap: preload frame_cnt to 16'hFFFF via 65535 frames (or force) -> the next boundary gives frame_cnt=0 and frame_done=1 for 1 cycle.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Frame-buffer pixel fetch for a scaled VGA image: address generation, palette
// lookup, border/transparency handling and frame-aligned double-buffer swap.
module vga_pixel_fetch #(
    parameter int          IMG_W       = 160,
    parameter int          IMG_H       = 120,
    parameter int          SCALE_SHIFT = 2,
    parameter int          ADDR_W      = 16,
    parameter logic [11:0] BORDER_RGB  = 12'h000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_rdata,
    output logic [7:0]        pal_addr,
    input  logic [11:0]       pal_rdata,
    input  logic              transp_en,
    input  logic [7:0]        transp_idx,
    input  logic              swap_req,
    output logic [11:0]       rgb,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              bank_sel,
    output logic              swap_ack,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_e;

    localparam logic [ADDR_W-1:0] BANK_OFS = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(IMG_W);

    swap_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [2:0]        vid_q, vid_d;
    logic [2:0]        img_q, img_d;
    logic [2:0]        hs_q, hs_d;
    logic [2:0]        vs_q, vs_d;
    logic              transp_q, transp_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hsync_out_q, hsync_out_d;
    logic              vsync_out_q, vsync_out_d;
    logic              bank_sel_q, bank_sel_d;
    logic              swap_ack_q, swap_ack_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [9:0]        col;
    logic [9:0]        row;
    logic              in_img;
    logic              boundary;
    logic [ADDR_W-1:0] lin_addr;

    assign col      = x >> SCALE_SHIFT;
    assign row      = y >> SCALE_SHIFT;
    assign in_img   = video_on
                    && ({22'd0, col} < 32'(IMG_W))
                    && ({22'd0, row} < 32'(IMG_H));
    assign boundary = (x == 10'd639) && (y == 10'd479);
    // row < IMG_H whenever in_img, so the product never overflows ADDR_W
    assign lin_addr = ADDR_W'(row) * ROW_W + ADDR_W'(col);

    always_comb begin
        fb_addr_d = fb_addr_q;
        if (in_img) begin
            fb_addr_d = lin_addr + (bank_sel_q ? BANK_OFS : '0);
        end

        // bit 0 = stage 1 (fb_addr), bit 1 = stage 2 (fb_rdata), bit 2 = stage 3
        vid_d = {vid_q[1:0], video_on};
        img_d = {img_q[1:0], in_img};
        hs_d  = {hs_q[1:0], hsync_in};
        vs_d  = {vs_q[1:0], vsync_in};

        transp_d = transp_en && (fb_rdata == transp_idx);

        rgb_d = 12'h000;
        if (vid_q[2]) begin
            if (img_q[2] && !transp_q) begin
                rgb_d = pal_rdata;
            end else begin
                rgb_d = BORDER_RGB;
            end
        end
        hsync_out_d = hs_q[2];
        vsync_out_d = vs_q[2];
    end

    always_comb begin
        state_d      = state_q;
        bank_sel_d   = bank_sel_q;
        swap_ack_d   = 1'b0;
        frame_done_d = boundary;
        frame_cnt_d  = frame_cnt_q;
        if (boundary) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        // bank only flips at the end of the visible frame
        if (boundary && (state_q == PENDING || swap_req)) begin
            bank_sel_d = ~bank_sel_q;
            swap_ack_d = 1'b1;
            state_d    = IDLE;
        end else if (swap_req && state_q == IDLE) begin
            state_d = PENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fb_addr_q    <= '0;
            vid_q        <= '0;
            img_q        <= '0;
            hs_q         <= '0;
            vs_q         <= '0;
            transp_q     <= 1'b0;
            rgb_q        <= '0;
            hsync_out_q  <= 1'b0;
            vsync_out_q  <= 1'b0;
            bank_sel_q   <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fb_addr_q    <= fb_addr_d;
            vid_q        <= vid_d;
            img_q        <= img_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            transp_q     <= transp_d;
            rgb_q        <= rgb_d;
            hsync_out_q  <= hsync_out_d;
            vsync_out_q  <= vsync_out_d;
            bank_sel_q   <= bank_sel_d;
            swap_ack_q   <= swap_ack_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign pal_addr   = fb_rdata;
    assign rgb        = rgb_q;
    assign hsync_out  = hsync_out_q;
    assign vsync_out  = vsync_out_q;
    assign bank_sel   = bank_sel_q;
    assign swap_ack   = swap_ack_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: default instance A plus instance B with a
// narrower image and a visible border colour, sharing the same stimulus.
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        video_on, hsync_in, vsync_in;
    logic        transp_en, swap_req;
    logic [7:0]  transp_idx;

    logic [15:0] fba_addr, fbb_addr;
    logic [7:0]  fba_rdata, fbb_rdata, pala_addr, palb_addr;
    logic [11:0] pala_rdata, palb_rdata, rgba, rgbb;
    logic        hsa, vsa, hsb, vsb;
    logic        banka, bankb, acka, ackb, donea, doneb;
    logic [15:0] fca, fcb;

    int total = 0;
    int bad   = 0;
    int exp_fc;

    always #20 clk = ~clk;

    vga_pixel_fetch dut_a (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .fb_addr(fba_addr),
        .fb_rdata(fba_rdata), .pal_addr(pala_addr), .pal_rdata(pala_rdata),
        .transp_en(transp_en), .transp_idx(transp_idx), .swap_req(swap_req),
        .rgb(rgba), .hsync_out(hsa), .vsync_out(vsa), .bank_sel(banka),
        .swap_ack(acka), .frame_done(donea), .frame_cnt(fca)
    );

    vga_pixel_fetch #(.IMG_W(100), .BORDER_RGB(12'h5A5)) dut_b (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .fb_addr(fbb_addr),
        .fb_rdata(fbb_rdata), .pal_addr(palb_addr), .pal_rdata(palb_rdata),
        .transp_en(transp_en), .transp_idx(transp_idx), .swap_req(swap_req),
        .rgb(rgbb), .hsync_out(hsb), .vsync_out(vsb), .bank_sel(bankb),
        .swap_ack(ackb), .frame_done(doneb), .frame_cnt(fcb)
    );

    // Memory models: frame buffer returns the low address byte,
    // palette returns {idx[3:0], idx} except index 2A maps to F80.
    function automatic logic [11:0] pal_f(input logic [7:0] i);
        return (i == 8'h2A) ? 12'hF80 : {i[3:0], i};
    endfunction

    always_ff @(posedge clk) begin
        fba_rdata  <= fba_addr[7:0];
        fbb_rdata  <= fbb_addr[7:0];
        pala_rdata <= pal_f(pala_addr);
        palb_rdata <= pal_f(palb_addr);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] xv, input logic [9:0] yv,
                         input logic von, input logic sw);
        x        = xv;
        y        = yv;
        video_on = von;
        swap_req = sw;
    endtask

    typedef struct {
        logic [9:0]  x, y;
        logic        von, hs, vs, ten;
        logic [7:0]  tidx;
        logic [15:0] a_addr;
        logic [11:0] a_rgb;
        logic [15:0] b_addr;
        logic [11:0] b_rgb;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{10'd5,   10'd9,   1, 1, 0, 0, 8'h00, 16'd321,   12'h141, 16'd201,   12'h9C9};
        vt[1]  = '{10'd168, 10'd0,   1, 0, 1, 0, 8'h00, 16'd42,    12'hF80, 16'd42,    12'hF80};
        vt[2]  = '{10'd400, 10'd8,   1, 0, 0, 0, 8'h00, 16'd420,   12'h4A4, 16'd42,    12'h5A5};
        vt[3]  = '{10'd5,   10'd9,   1, 1, 1, 1, 8'h41, 16'd321,   12'h000, 16'd201,   12'h9C9};
        vt[4]  = '{10'd5,   10'd9,   1, 0, 1, 1, 8'hC9, 16'd321,   12'h141, 16'd201,   12'h5A5};
        vt[5]  = '{10'd5,   10'd9,   1, 1, 0, 0, 8'hC9, 16'd321,   12'h141, 16'd201,   12'h9C9};
        vt[6]  = '{10'd5,   10'd9,   0, 1, 1, 0, 8'h00, 16'd321,   12'h000, 16'd201,   12'h000};
        vt[7]  = '{10'd0,   10'd480, 1, 0, 1, 0, 8'h00, 16'd321,   12'h000, 16'd201,   12'h5A5};
        vt[8]  = '{10'd636, 10'd476, 1, 1, 0, 0, 8'h00, 16'd19199, 12'hFFF, 16'd201,   12'h5A5};
        vt[9]  = '{10'd396, 10'd476, 1, 0, 0, 0, 8'h00, 16'd19139, 12'h3C3, 16'd11999, 12'hFDF};
        vt[10] = '{10'd0,   10'd0,   1, 1, 1, 1, 8'h00, 16'd0,     12'h000, 16'd0,     12'h5A5};
        vt[11] = '{10'd7,   10'd4,   1, 0, 0, 0, 8'h00, 16'd161,   12'h1A1, 16'd101,   12'h565};

        reset_n    = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        transp_en  = 1'b0;
        transp_idx = 8'h00;
        drive(10'd5, 10'd9, 1'b1, 1'b0);
        repeat (3) cyc();

        chk("rst_fb_addr", 32'(fba_addr), 32'd0);
        chk("rst_rgb", 32'(rgba), 32'd0);
        chk("rst_hsync", 32'(hsa), 32'd0);
        chk("rst_vsync", 32'(vsa), 32'd0);
        chk("rst_bank", 32'(banka), 32'd0);
        chk("rst_fcnt", 32'(fca), 32'd0);
        reset_n = 1'b1;
        exp_fc  = 0;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].x, vt[i].y, vt[i].von, 1'b0);
            hsync_in   = vt[i].hs;
            vsync_in   = vt[i].vs;
            transp_en  = vt[i].ten;
            transp_idx = vt[i].tidx;
            repeat (6) cyc();
            chk($sformatf("v%0d_a_addr", i), 32'(fba_addr), 32'(vt[i].a_addr));
            chk($sformatf("v%0d_a_rgb", i), 32'(rgba), 32'(vt[i].a_rgb));
            chk($sformatf("v%0d_b_addr", i), 32'(fbb_addr), 32'(vt[i].b_addr));
            chk($sformatf("v%0d_b_rgb", i), 32'(rgbb), 32'(vt[i].b_rgb));
            chk($sformatf("v%0d_hs", i), 32'({hsa, hsb}), 32'({vt[i].hs, vt[i].hs}));
            chk($sformatf("v%0d_vs", i), 32'({vsa, vsb}), 32'({vt[i].vs, vt[i].vs}));
        end

        // Latency: pixel at (168,0) with a rising hsync edge
        drive(10'd168, 10'd0, 1'b1, 1'b0);
        hsync_in = 1'b1;
        cyc();
        chk("lat_addr_t1", 32'(fba_addr), 32'd42);
        chk("lat_rgb_t1", 32'(rgba), 32'h1A1);
        cyc();
        chk("lat_fbdata_t2", 32'(fba_rdata), 32'h2A);
        cyc();
        chk("lat_rgb_t3", 32'(rgba), 32'h1A1);
        chk("lat_hs_t3", 32'(hsa), 32'd0);
        cyc();
        chk("lat_rgb_t4", 32'(rgba), 32'hF80);
        chk("lat_hs_t4", 32'(hsa), 32'd1);

        // Swap requested mid-frame, then a redundant second request
        drive(10'd0, 10'd100, 1'b0, 1'b1);
        cyc();
        swap_req = 1'b0;
        chk("sw_hold0", 32'({banka, acka}), 32'd0);
        drive(10'd0, 10'd200, 1'b0, 1'b1);
        cyc();
        swap_req = 1'b0;
        y = 10'd300;
        repeat (3) cyc();
        chk("sw_hold1", 32'({banka, acka}), 32'd0);

        drive(10'd639, 10'd479, 1'b0, 1'b0);
        cyc();
        exp_fc++;
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        chk("sw_bank1", 32'(banka), 32'd1);
        chk("sw_ack1", 32'(acka), 32'd1);
        chk("sw_done1", 32'(donea), 32'd1);
        chk("sw_fc1", 32'(fca), 32'(exp_fc));
        cyc();
        chk("sw_after", 32'({banka, acka, donea}), 32'b100);

        drive(10'd5, 10'd9, 1'b1, 1'b0);
        cyc();
        chk("bank1_addr_a", 32'(fba_addr), 32'd19521);
        chk("bank1_addr_b", 32'(fbb_addr), 32'd12201);

        drive(10'd639, 10'd479, 1'b0, 1'b0);
        cyc();
        exp_fc++;
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        chk("noq_bank", 32'({banka, acka}), 32'b10);
        chk("noq_fc", 32'(fca), 32'(exp_fc));

        // Request arriving in the boundary cycle itself
        drive(10'd639, 10'd479, 1'b0, 1'b1);
        cyc();
        exp_fc++;
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        chk("bnd_req", 32'({banka, acka, bankb}), 32'b010);
        chk("bnd_fc", 32'(fca), 32'(exp_fc));

        // Reset while a swap is pending
        drive(10'd5, 10'd9, 1'b1, 1'b1);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        cyc();
        swap_req = 1'b0;
        repeat (5) cyc();
        chk("pre_rst_rgb", 32'(rgba), 32'h141);
        reset_n = 1'b0;
        cyc();
        chk("mid_rst_addr", 32'(fba_addr), 32'd0);
        chk("mid_rst_out", 32'({rgba, hsa, vsa}), 32'd0);
        chk("mid_rst_ctl", 32'({banka, acka, donea, fca}), 32'd0);
        reset_n  = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        drive(10'd639, 10'd479, 1'b0, 1'b0);
        cyc();
        chk("post_rst_noswap", 32'({banka, acka, donea}), 32'b001);
        chk("post_rst_fc", 32'(fca), 32'd1);

        // Every cycle is a boundary while x/y sit at 639/479
        repeat (65534) cyc();
        chk("wrap_ffff", 32'(fca), 32'hFFFF);
        cyc();
        chk("wrap_zero", 32'(fca), 32'd0);
        chk("wrap_done", 32'(donea), 32'd1);
        chk("wrap_bank", 32'(banka), 32'd0);
        drive(10'd0, 10'd0, 1'b0, 1'b0);
        cyc();
        chk("wrap_done_end", 32'({donea, fca}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
